// File: rtl/starfield_speed_ramp_if.sv
// CPU register port and starfield write port of the speed ramp, bundled as one bus.
interface starfield_speed_ramp_if;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_data_in;
  logic       cpu_write;
  logic [7:0] cpu_data_out;
  logic       vblank;
  logic [7:0] sf_data_out;
  logic       sf_write;
  logic       at_target;
  logic       busy;

  modport master (
    output cpu_addr, cpu_data_in, cpu_write, vblank,
    input  cpu_data_out, sf_data_out, sf_write, at_target, busy
  );

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_write, vblank,
    output cpu_data_out, sf_data_out, sf_write, at_target, busy
  );
endinterface

// File: rtl/starfield_speed_ramp.sv
// Starfield speed ramp: steps a current speed toward a CPU-programmed target on
// divided vblank rising edges and issues one starfield write per change.
module starfield_speed_ramp #(
  parameter int         DIV_W    = 8,
  parameter logic [7:0] RATE_RST = 8'd1
) (
  input  logic                 clk,
  input  logic                 rst,
  starfield_speed_ramp_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STEP, ISSUE} state_t;

  state_t             state, state_n;
  logic [7:0]         target, rate, current, current_n;
  logic [DIV_W-1:0]   div, divcnt, div_wdata;
  logic               enable, vblank_q;
  logic               vb_rise, tick, imm;
  logic [7:0]         div_rd;

  // Saturating increment: 9-bit sum so a large rate clamps at target instead of wrapping.
  function automatic logic [7:0] step_up(input logic [7:0] cur, input logic [7:0] tgt,
                                         input logic [7:0] rt);
    logic [8:0] sum;
    sum = {1'b0, cur} + {1'b0, rt};
    return (sum > {1'b0, tgt}) ? tgt : sum[7:0];
  endfunction

  // Saturating decrement: 9-bit signed difference so a large rate clamps at target.
  function automatic logic [7:0] step_down(input logic [7:0] cur, input logic [7:0] tgt,
                                           input logic [7:0] rt);
    logic signed [8:0] diff;
    diff = $signed({1'b0, cur}) - $signed({1'b0, rt});
    return (diff < $signed({1'b0, tgt})) ? tgt : diff[7:0];
  endfunction

  assign vb_rise       = bus.vblank & ~vblank_q;
  assign tick          = vb_rise & enable & (divcnt == div);
  assign imm           = bus.cpu_write & (bus.cpu_addr == 2'd3) & bus.cpu_data_in[1];
  assign bus.at_target = (current == target);
  assign bus.busy      = (state != IDLE);

  // Fit the 8-bit CPU byte to the divider width (zero-extend or truncate).
  always_comb begin
    div_wdata = '0;
    for (int i = 0; i < DIV_W; i++)
      if (i < 8) div_wdata[i] = bus.cpu_data_in[i % 8];
  end

  // Fit the divider back to the 8-bit readback width.
  always_comb begin
    div_rd = '0;
    for (int i = 0; i < 8; i++)
      if (i < DIV_W) div_rd[i] = div[i % DIV_W];
  end

  // Combinational register readback selected by cpu_addr.
  always_comb begin
    bus.cpu_data_out = target;
    case (bus.cpu_addr)
      2'd0:    bus.cpu_data_out = target;
      2'd1:    bus.cpu_data_out = rate;
      2'd2:    bus.cpu_data_out = div_rd;
      default: bus.cpu_data_out = current;
    endcase
  end

  // CPU-programmable registers; the immediate bit is a command and is never stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= 8'd0;
      rate   <= RATE_RST;
      div    <= '0;
      enable <= 1'b0;
    end else if (bus.cpu_write) begin
      case (bus.cpu_addr)
        2'd0:    target <= bus.cpu_data_in;
        2'd1:    rate   <= bus.cpu_data_in;
        2'd2:    div    <= div_wdata;
        default: enable <= bus.cpu_data_in[0];
      endcase
    end
  end

  // Vblank edge history and frame divider; the divider keeps counting while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblank_q <= 1'b1;
      divcnt   <= '0;
    end else begin
      vblank_q <= bus.vblank;
      if (!enable)
        divcnt <= '0;
      else if (vb_rise)
        divcnt <= (divcnt == div) ? '0 : divcnt + 1'b1;
    end
  end

  // Next state and next speed; an immediate command overrides whatever is in flight.
  always_comb begin
    state_n   = state;
    current_n = current;
    case (state)
      IDLE:  if (tick) state_n = STEP;
      STEP: begin
        if (current < target)
          current_n = step_up(current, target, rate);
        else if (current > target)
          current_n = step_down(current, target, rate);
        state_n = (current_n != current) ? ISSUE : IDLE;
      end
      ISSUE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (imm) begin
      state_n   = ISSUE;
      current_n = target;
    end
  end

  // State, current speed and the registered starfield write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      current         <= 8'd0;
      bus.sf_write    <= 1'b0;
      bus.sf_data_out <= 8'd0;
    end else begin
      state        <= state_n;
      current      <= current_n;
      bus.sf_write <= (state_n == ISSUE);
      if (state_n == ISSUE)
        bus.sf_data_out <= current_n;
    end
  end

endmodule

// File: tb/tb_starfield_speed_ramp.sv
// Bench for starfield_speed_ramp: directed scenarios plus random CPU/vblank
// traffic, checked by a scoreboard fed from a frame-level reference model.
module tb_starfield_speed_ramp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  starfield_speed_ramp_if bus ();

  starfield_speed_ramp #(.DIV_W(8), .RATE_RST(8'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] data;
    longint     at;
  } exp_t;
  exp_t sbq[$];

  // reference model state
  int m_tgt, m_rate, m_div, m_cur, m_cnt;
  bit m_en;

  function automatic void check(string name, longint act, longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void reset_model();
    m_tgt = 0; m_rate = 1; m_div = 0; m_cur = 0; m_cnt = 0; m_en = 0;
  endfunction

  function automatic void model_write(input logic [1:0] a, input logic [7:0] d, input longint c);
    case (a)
      2'd0: m_tgt  = d;
      2'd1: m_rate = d;
      2'd2: m_div  = d;
      default: begin
        m_en = d[0];
        if (!m_en) m_cnt = 0;
        if (d[1]) begin
          m_cur = m_tgt;
          sbq.push_back('{data: 8'(m_tgt), at: c + 1});
        end
      end
    endcase
  endfunction

  // returns 1 when this vblank rise produces a tick
  function automatic bit model_tick();
    if (!m_en) begin
      m_cnt = 0;
      return 0;
    end
    if (m_cnt == m_div) begin
      m_cnt = 0;
      return 1;
    end
    m_cnt = (m_cnt + 1) % 256;
    return 0;
  endfunction

  function automatic void model_step(input longint c);
    int nxt;
    nxt = m_cur;
    if (m_cur < m_tgt)      nxt = (m_cur + m_rate > m_tgt) ? m_tgt : m_cur + m_rate;
    else if (m_cur > m_tgt) nxt = (m_cur - m_rate < m_tgt) ? m_tgt : m_cur - m_rate;
    if (nxt != m_cur) sbq.push_back('{data: 8'(nxt), at: c + 2});
    m_cur = nxt;
  endfunction

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.cpu_addr = a; bus.cpu_data_in = d; bus.cpu_write = 1'b1;
    model_write(a, d, cyc);
    @(posedge clk); #1;
    bus.cpu_write = 1'b0;
  endtask

  task automatic frame();
    @(posedge clk); #1;
    bus.vblank = 1'b1;
    if (model_tick()) model_step(cyc);
    repeat (2) @(posedge clk);
    #1 bus.vblank = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic check_regs(input string tag);
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      bus.cpu_addr = 2'(a);
      #1;
      case (a)
        0: check({tag, "_target"},  bus.cpu_data_out, m_tgt);
        1: check({tag, "_rate"},    bus.cpu_data_out, m_rate);
        2: check({tag, "_div"},     bus.cpu_data_out, m_div % 256);
        default: check({tag, "_current"}, bus.cpu_data_out, m_cur);
      endcase
    end
    check({tag, "_at_target"}, bus.at_target, (m_cur == m_tgt));
  endtask

  // scoreboard monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && bus.sf_write) begin
      if (sbq.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_strobe: got data %0d at cycle %0d, required no strobe",
                 bus.sf_data_out, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sf_data", bus.sf_data_out, e.data);
        check("sf_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bus.cpu_addr = 2'd0; bus.cpu_data_in = 8'd0; bus.cpu_write = 1'b0;
    bus.vblank = 1'b1;
    rst = 1'b1;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sf_write",  bus.sf_write, 0);
    check("rst_sf_data",   bus.sf_data_out, 0);
    check("rst_busy",      bus.busy, 0);
    check("rst_at_target", bus.at_target, 1);
    rst = 1'b0;
    // disabled: three frames, no writes expected
    repeat (3) frame();
    check_regs("post_reset");

    // ramp up 16, 32, 40, then nothing
    cpu_wr(2'd0, 8'd40); cpu_wr(2'd1, 8'd16); cpu_wr(2'd2, 8'd0); cpu_wr(2'd3, 8'd1);
    repeat (4) frame();
    check_regs("ramp_up");

    // big rate downward clamps at target
    cpu_wr(2'd0, 8'd5); cpu_wr(2'd1, 8'd200);
    repeat (2) frame();
    check_regs("ramp_down");

    // reset current to 0, then divided ramp to 250, then saturate at 255
    cpu_wr(2'd0, 8'd0); cpu_wr(2'd3, 8'b011);
    cpu_wr(2'd0, 8'd250); cpu_wr(2'd1, 8'd10); cpu_wr(2'd2, 8'd2);
    repeat (75) frame();
    check_regs("div_ramp");
    cpu_wr(2'd2, 8'd0); cpu_wr(2'd0, 8'd255);
    repeat (2) frame();
    check_regs("top_clamp");

    // immediate from idle
    cpu_wr(2'd0, 8'd77); cpu_wr(2'd3, 8'b011);
    check_regs("immediate");

    // immediate landing in STEP overrides the step value
    cpu_wr(2'd0, 8'd100);
    @(posedge clk); #1;
    bus.vblank = 1'b1;
    begin
      longint c0;
      c0 = cyc;
      if (model_tick()) begin
        m_cur = m_tgt;
        sbq.push_back('{data: 8'(m_tgt), at: c0 + 2});
      end
    end
    @(posedge clk); #1;
    bus.cpu_addr = 2'd3; bus.cpu_data_in = 8'b011; bus.cpu_write = 1'b1;
    @(posedge clk); #1;
    bus.cpu_write = 1'b0;
    @(posedge clk); #1 bus.vblank = 1'b0;
    repeat (5) @(posedge clk);
    check_regs("imm_in_step");

    // zero rate never moves
    cpu_wr(2'd1, 8'd0); cpu_wr(2'd0, 8'd10);
    repeat (5) frame();
    check_regs("rate_zero");

    // reset while the strobe is high
    @(posedge clk); #1;
    bus.cpu_addr = 2'd3; bus.cpu_data_in = 8'b011; bus.cpu_write = 1'b1;
    @(posedge clk); #1;
    bus.cpu_write = 1'b0;
    check("issue_strobe", bus.sf_write, 1);
    check("issue_data",   bus.sf_data_out, 10);
    rst = 1'b1;
    #1;
    check("rst_drops_strobe", bus.sf_write, 0);
    reset_model();
    @(posedge clk); #1 rst = 1'b0;
    check("rst2_sf_data", bus.sf_data_out, 0);
    check("rst2_busy",    bus.busy, 0);
    check_regs("mid_issue_reset");

    // random traffic against the model
    repeat (200) begin
      case ($urandom_range(0, 9))
        0: cpu_wr(2'd0, 8'($urandom_range(0, 255)));
        1: cpu_wr(2'd1, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(0, 40)));
        2: cpu_wr(2'd2, 8'($urandom_range(0, 2)));
        3: cpu_wr(2'd3, {6'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0)});
        default: frame();
      endcase
    end
    check_regs("random_end");

    repeat (10) @(posedge clk);
    check("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/starfield_speed_ramp.md
Name: starfield_speed_ramp

Overview:
CPU-side transmitter that drives the starfield speed write port (8-bit data plus 1-cycle write strobe).
The CPU programs a target speed, step size and frame divider. On qualifying vblank rising edges the block steps its current speed toward the target and issues one write per change.
It sits between the CPU register decode and the starfield block, so software gets smooth accelerate/decelerate without per-frame CPU writes.

Parameters:
DIV_W, 8, width of frame divider register/counter
RATE_RST, 8'd1, reset value of step-size register

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cpu_addr  in  2  register select
cpu_data_in  in  8  CPU write data
cpu_write  in  1  CPU write strobe, one cycle per write
cpu_data_out  out  8  readback (combinational on cpu_addr)
vblank  in  1  vertical blank level from video timing
sf_data_out  out  8  speed value to starfield data_in
sf_write  out  1  1-cycle write strobe to starfield write
at_target  out  1  current speed == target speed
busy  out  1  step/issue in progress

Behaviour:
- Registers (written when cpu_write=1):
  - addr0: target.
  - addr1: rate.
  - addr2: div.
  - addr3: control. bit0 = enable; bit1 = immediate (self-clearing, never stored); other bits ignored.
- Readback via cpu_data_out:
  - addr0 → target; addr1 → rate; addr2 → div (zero-extended/truncated to 8); addr3 → current.
- Reset values (async, all immediate):
  - target=0, rate=RATE_RST, div=0, enable=0, current=0, divcnt=0.
  - vblank_q=1, so no spurious edge if vblank is high at reset release.
  - State IDLE; sf_write=0, sf_data_out=0, busy=0, at_target=1.
- Edge detection: vb_rise = vblank & ~vblank_q; vblank_q registered every cycle.
- Tick generation:
  - On vb_rise with enable=1: if divcnt==div, then tick and divcnt←0; else divcnt←divcnt+1.
  - On vb_rise with enable=0: divcnt is held at 0.
- FSM states: IDLE, STEP, ISSUE.
  - IDLE: on tick → STEP. On immediate → ISSUE with current←target.
  - STEP (busy=1):
    - current<target: current←min(current+rate, target), computed 9-bit, no wrap.
    - current>target: current←max(current−rate, target), computed 9-bit signed, no underflow.
    - If current changed → ISSUE, else → IDLE.
    - rate=0 or current==target: no change, no write.
  - ISSUE (busy=1): sf_write=1 for exactly one cycle, sf_data_out=current (registered, held after strobe). → IDLE.
- Latency: vb_rise sampled at cycle N → STEP at N+1 → sf_write high at N+2 with the new value.
- Immediate:
  - Write to addr3 with bit1=1 → sf_write at the next cycle with sf_data_out=target (its value after the same-cycle write, if any).
  - Immediate is honoured regardless of enable.
  - Immediate in STEP or ISSUE overrides: the next cycle is ISSUE with current←target. At most one strobe per cycle; never two back-to-back strobes for one event.
- Simultaneous events:
  - CPU write to target or rate in the same cycle as STEP: STEP uses the old values; new values take effect from the next tick.
  - vb_rise while busy: tick lost. divcnt still advances.
- Clearing enable mid-ramp: an in-flight STEP/ISSUE completes; no further ticks.
- at_target: combinational (current==target).
- Reset mid-ISSUE: sf_write drops immediately (async).

Test Plan:
- Reset with vblank held high, release → no sf_write over 3 frames; cpu_data_out at addr1 reads 8'd1; at_target=1.
- target=40, rate=16, div=0, enable=1; pulse vblank 4 times → sf_write once per frame with data 16, 32, 40; no write on the 4th; at_target=1 after the 3rd; each strobe exactly 2 cycles after vblank rise.
- Then target=5, rate=200 → next frame writes 5 (clamped, no underflow); next frame no write.
- current=0, target=250, rate=10, div=2 → writes only on every 3rd vblank rise; values 10, 20, …, 250; final step does not wrap past 255.
- Immediate: write addr0=77, then addr3=8'b011 → sf_write next cycle with data 77, current reads 77. Repeat with the immediate write landing in STEP → single strobe with target value, no extra strobe.
- rate=0 with target≠current over 5 frames → no sf_write, at_target=0. Assert rst during ISSUE → sf_write drops the same cycle; all registers at reset values.
